// File: rtl/circ_rot_pkg.sv
// circ_rot_pkg: shared state, direction and width constants for the sequential rotator
package circ_rot_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} rotState;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT = 1'b1;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/circ_rot_step.sv
// circ_rot_step: combinational rotate by STEP positions, right (dir=0) or left (dir=1)
module circ_rot_step import circ_rot_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP = 1
) (
  input  logic [WIDTH-1:0] word,
  input  logic             dir,
  output logic [WIDTH-1:0] rotated
);
  always_comb rotated = (dir == DIR_LEFT) ? {word[WIDTH-STEP-1:0], word[WIDTH-1:WIDTH-STEP]}
                                          : {word[STEP-1:0], word[WIDTH-1:STEP]};
endmodule

// File: rtl/circ_rot_seq.sv
// circ_rot_seq: multi-cycle circular rotator with start/busy/done; CIRC_ROT_BARREL_EN selects single-cycle barrel
module circ_rot_seq import circ_rot_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [SHW-1:0]   amt,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);
  rotState state, nextState;
  logic [WIDTH-1:0] dataReg, dataNext, rotWord;
  logic [SHW-1:0] cnt, cntNext;
  logic dirReg, dirNext;
`ifdef CIRC_ROT_BARREL_EN
  logic [SHW:0][WIDTH-1:0] stage;
  logic [SHW-1:0][WIDTH-1:0] stepOut;
  assign stage[0] = dataReg;
  for (genvar k = 0; k < SHW; k++) begin : g_barrel
    circ_rot_step #(.WIDTH(WIDTH), .STEP(1 << k)) uStep (
      .word(stage[k]),
      .dir(dirReg),
      .rotated(stepOut[k])
    );
    assign stage[k+1] = cnt[k] ? stepOut[k] : stage[k];
  end
  assign rotWord = stage[SHW];
`else
  circ_rot_step #(.WIDTH(WIDTH), .STEP(1)) uStep (
    .word(dataReg),
    .dir(dirReg),
    .rotated(rotWord)
  );
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dataReg <= '0;
      cnt <= '0;
      dirReg <= DIR_RIGHT;
    end else begin
      state <= nextState;
      dataReg <= dataNext;
      cnt <= cntNext;
      dirReg <= dirNext;
    end
  end
  // IDLE and DONE both accept a new job, which gives back-to-back operation
  always_comb begin
    nextState = state;
    dataNext = dataReg;
    cntNext = cnt;
    dirNext = dirReg;
    if (state != SHIFT) begin
      nextState = start ? ((amt == '0) ? DONE : SHIFT) : IDLE;
      dataNext = start ? din : dataReg;
      cntNext = start ? amt : cnt;
      dirNext = start ? dir : dirReg;
    end else begin
      dataNext = rotWord;
`ifdef CIRC_ROT_BARREL_EN
      cntNext = '0;
      nextState = DONE;
`else
      cntNext = cnt - SHW'(1);
      nextState = (cnt == SHW'(1)) ? DONE : SHIFT;
`endif
    end
  end
  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign dout = dataReg;
endmodule

// File: tb/tb_circ_rot_seq.sv
// tb_circ_rot_seq: directed and exhaustive self-checking bench for circ_rot_seq
module tb_circ_rot_seq;
  logic clk = 0, rst_n = 0, start = 0, dir = 0;
  logic [2:0] amt = '0;
  logic [7:0] din = '0;
  logic busy, done;
  logic [7:0] dout;
  int checks = 0, errors = 0;

  circ_rot_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .amt(amt),
    .din(din), .busy(busy), .done(done), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] refRot(input logic [7:0] d, input logic dr, input int a);
    logic [15:0] dd;
    dd = {d, d};
    return dr ? 8'((dd << a) >> 8) : 8'(dd >> a);
  endfunction

  function automatic int expLat(input int a);
`ifdef CIRC_ROT_BARREL_EN
    return (a == 0) ? 0 : 1;
`else
    return a;
`endif
  endfunction

  task automatic runJob(input logic [7:0] d, input logic dr, input logic [2:0] a,
                        output logic [7:0] res, output int lat, output int busyCyc);
    din = d; dir = dr; amt = a; start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = 0; busyCyc = 0;
    while (!done && lat < 20) begin
      busyCyc += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", done, 1);
    res = dout;
    @(posedge clk); #1;
    chk("done_width", done, 0);
  endtask

  logic [7:0] res;
  int lat, bc, dn;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    rst_n = 1;
    @(posedge clk); #1;

    runJob(8'b1000_0001, 0, 1, res, lat, bc);
    chk("r1_dout", res, 8'b1100_0000);
    chk("r1_lat", lat, 1);
    chk("r1_busy", bc, 1);

    runJob(8'h96, 1, 3, res, lat, bc);
    chk("l3_dout", res, 8'hB4);
    chk("l3_busy", bc, expLat(3));
    runJob(8'hB4, 0, 3, res, lat, bc);
    chk("r3_dout", res, 8'h96);

    runJob(8'h5A, 0, 0, res, lat, bc);
    chk("z_dout", res, 8'h5A);
    chk("z_lat", lat, 0);
    chk("z_busy", bc, 0);

    runJob(8'h01, 0, 7, res, lat, bc);
    chk("r7_dout", res, 8'h02);
    chk("r7_lat", lat, expLat(7));

    // intruding start while busy must be ignored
    din = 8'hF0; dir = 1; amt = 5; start = 1;
    dn = 0; res = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      start = (i == 1) && busy;
      if (start) begin din = 8'h0F; dir = 0; amt = 1; end
      if (done) begin dn++; res = dout; end
    end
    chk("ign_dout", res, 8'h1E);
    chk("ign_dones", dn, 1);

    // back-to-back: new start in the DONE cycle
    din = 8'h3C; dir = 0; amt = 2; start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = 0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("b2b_first", dout, 8'h0F);
    din = 8'h80; dir = 1; amt = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("b2b_busy", busy, 1);
    chk("b2b_nodone", done, 0);
    @(posedge clk); #1;
    chk("b2b_done", done, 1);
    chk("b2b_dout", dout, 8'h01);
    @(posedge clk); #1;

    // reset abort in SHIFT cycle 2 of an amt=6 job
    din = 8'hA5; dir = 0; amt = 6; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dout", dout, 0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort_nodone", dn, 0);

    for (int d = 0; d < 256; d++)
      for (int a = 0; a < 8; a++)
        for (int r = 0; r < 2; r++) begin
          runJob(8'(d), 1'(r), 3'(a), res, lat, bc);
          chk("ex_dout", res, refRot(8'(d), 1'(r), a));
          chk("ex_lat", lat, expLat(a));
        end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
